// File: rtl/button_event_scheduler_pkg.sv
// Shared definitions for the button event scheduler.
//   state_e            : offer FSM state (S_IDLE, S_OFFER)
//   DEF_NUM_REQ        : default requester count
//   DEF_HOLDOFF_CYCLES : default per-requester lockout length
//   id_width()         : width of a requester index
package button_event_scheduler_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_e;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 16;

    // Never returns 0 so index vectors stay legal for degenerate counts.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Event handshake between the scheduler and its consumer.
//   ev_valid : an event is offered on ev_id
//   ev_id    : index of the offered requester
//   ev_ready : consumer accepts the event
// Modports: master (scheduler side), slave (consumer side).
interface button_event_scheduler_if
    import button_event_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic           ev_valid;
    logic [IdW-1:0] ev_id;
    logic           ev_ready;

    modport master (
        output ev_valid,
        output ev_id,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        output ev_ready
    );

endinterface

// File: rtl/button_event_scheduler_rr_pick.sv
// Combinational round-robin search.
//   req_i     : request vector, bit i = requester i
//   ptr_i     : index where the search starts
//   grant_o   : first requesting index at or after ptr_i (wrapping)
//   any_req_o : at least one request bit is set
module button_event_scheduler_rr_pick
    import button_event_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IdW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     ptr_i,
    output logic [IdW-1:0]     grant_o,
    output logic               any_req_o
);

    logic [IdW-1:0] idx;

    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IdW'((32'(ptr_i) + off) % NUM_REQ);
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                grant_o   = idx;
            end
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Collects one-cycle button press pulses and serves them one at a time over
// a valid/ready event port in round-robin order.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   pulse_in : press pulses, bit i = requester i
//   ev       : event handshake (master modport)
//   overrun  : sticky, bit i = a press on requester i was lost
//   busy     : any press pending or an event on offer
// Build option: define BTN_HOLDOFF_EN to lock a requester out for
// HOLDOFF_CYCLES cycles after each grant.
module button_event_scheduler
    import button_event_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        pulse_in,
    button_event_scheduler_if.master  ev,
    output logic [NUM_REQ-1:0]        overrun,
    output logic                      busy
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be in 1..255");
    end

    state_e             state_q, state_d;
    logic [IdW-1:0]     ev_id_q, ev_id_d;
    logic [IdW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] overrun_q, overrun_d;

    logic [IdW-1:0]     grant;
    logic               any_req;
    logic               do_grant;
    logic [NUM_REQ-1:0] clear_mask;
    logic [NUM_REQ-1:0] lockout;
    logic [NUM_REQ-1:0] accept;

    button_event_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (pending_q),
        .ptr_i     (ptr_q),
        .grant_o   (grant),
        .any_req_o (any_req)
    );

    // Offer FSM
    always_comb begin
        state_d  = state_q;
        ev_id_d  = ev_id_q;
        ptr_d    = ptr_q;
        do_grant = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    do_grant = 1'b1;
                    ev_id_d  = grant;
                    ptr_d    = (grant == IdW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state_d  = S_OFFER;
                end
            end
            S_OFFER: begin
                if (ev.ev_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        clear_mask = '0;
        if (do_grant) begin
            clear_mask[grant] = 1'b1;
        end
    end

    // A new press on the clearing edge re-arms the bit (set wins); a press on
    // a bit that stays pending is lost and flagged.
    always_comb begin
        accept    = pulse_in & ~lockout;
        pending_d = (pending_q & ~clear_mask) | accept;
        overrun_d = overrun_q | (accept & pending_q & ~clear_mask);
    end

`ifdef BTN_HOLDOFF_EN
    logic [7:0] holdoff_q [NUM_REQ];
    logic [7:0] holdoff_d [NUM_REQ];

    // Counter loads on the grant edge, so a press on that edge is still seen.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lockout[i]   = (holdoff_q[i] != 8'd0);
            holdoff_d[i] = holdoff_q[i];
            if (clear_mask[i]) begin
                holdoff_d[i] = 8'(HOLDOFF_CYCLES);
            end else if (holdoff_q[i] != 8'd0) begin
                holdoff_d[i] = holdoff_q[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                holdoff_q[i] <= 8'd0;
            end else begin
                holdoff_q[i] <= holdoff_d[i];
            end
        end
    end
`else
    assign lockout = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ev_id_q   <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            ev_id_q   <= ev_id_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign ev.ev_valid = (state_q == S_OFFER);
    assign ev.ev_id    = ev_id_q;
    assign overrun     = overrun_q;
    assign busy        = (|pending_q) | (state_q == S_OFFER);

endmodule

// File: doc/button_event_scheduler.md
BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of shaped-button requesters, legal range 2..8.
REQ-002 The block SHALL have parameter HOLDOFF_CYCLES, default 16: per-requester lockout length after a grant, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port pulse_in, input, NUM_REQ bits: one-cycle active-high press pulses from the button shapers, bit i = requester i.
REQ-006 The block SHALL have port ev_valid, output, 1 bit: an event is offered on ev_id.
REQ-007 The block SHALL have port ev_id, output, $clog2(NUM_REQ) bits: index of the offered requester.
REQ-008 The block SHALL have port ev_ready, input, 1 bit: the consumer accepts the event.
REQ-009 The block SHALL have port overrun, output, NUM_REQ bits: sticky flag, bit i = press lost on requester i.
REQ-010 The block SHALL have port busy, output, 1 bit: high when any pending bit is set or ev_valid is high.

Function
REQ-011 The block SHALL set pending[i] on the rising edge where pulse_in[i]=1 and requester i is not locked out.
REQ-012 The block SHALL set overrun[i] when pulse_in[i]=1 while pending[i]=1 and pending[i] is not being cleared on that edge; the pulse is dropped.
REQ-013 The block SHALL keep pending[i] set when pulse_in[i]=1 on the same edge that clears pending[i] (set wins); overrun[i] is unchanged.
REQ-014 The block SHALL have a two-state FSM: S_IDLE (ev_valid=0) and S_OFFER (ev_valid=1).
REQ-015 In S_IDLE with any pending bit set, on the next edge the block SHALL load ev_id with the round-robin winner, clear that pending bit and enter S_OFFER.
REQ-016 A pulse at edge N SHALL produce ev_valid=1 from cycle N+2 at the earliest, when no other request is pending.
REQ-017 In S_OFFER, ev_id SHALL stay stable while ev_ready=0; on an edge with ev_ready=1 the block SHALL return to S_IDLE.
REQ-018 Round-robin: the search SHALL start at pointer ptr; after granting i, ptr SHALL become (i+1) mod NUM_REQ.
REQ-019 ev_ready SHALL be ignored in S_IDLE.
REQ-020 Sustained throughput SHALL be one event per two cycles maximum.
REQ-021 overrun bits SHALL clear only on reset.

Reset
REQ-022 On an edge with rst=1, the block SHALL set: state S_IDLE, ev_valid=0, ev_id=0, pending=0, overrun=0, ptr=0, all holdoff counters=0, busy=0.
REQ-023 Reset mid-offer SHALL discard the offered event and all pending events; pulse_in on a reset edge SHALL be ignored.

Configuration
REQ-024 The macro BTN_HOLDOFF_EN SHALL select whether holdoff is built.
REQ-025 With BTN_HOLDOFF_EN defined, granting requester i SHALL load its 8-bit counter with HOLDOFF_CYCLES; the counter decrements each cycle; pulse_in[i] SHALL be ignored (no pending, no overrun) while the counter is nonzero.
REQ-026 Without BTN_HOLDOFF_EN, no counters SHALL exist, HOLDOFF_CYCLES SHALL be unused, and requesters SHALL never be locked out.

Structure
REQ-027 A shared package SHALL hold the FSM state type (S_IDLE, S_OFFER), the default NUM_REQ and HOLDOFF_CYCLES constants, and the ID-width function.
REQ-028 The round-robin search SHALL be a sub-module, rr_pick: inputs req vector and ptr; outputs grant index and any_req; purely combinational.

Verification
REQ-029 Single pulse: reset, then pulse_in=4'b0100 at edge 10 with ev_ready=1 -> ev_valid=1 and ev_id=2 in cycle 12 only, then busy=0.
REQ-030 Simultaneous pulses: pulse_in=4'b1111 in one cycle with ev_ready=1 -> ev_id sequence 0,1,2,3, one event every 2 cycles.
REQ-031 Backpressure: ev_ready=0 for 20 cycles during an offer of ev_id=1 -> ev_valid and ev_id held; accepted on the first ev_ready=1 edge.
REQ-032 Overrun: two pulses on requester 3 while an offer of requester 0 is stalled -> overrun=4'b1000 (sticky); exactly one event with ev_id=3.
REQ-033 Holdoff (BTN_HOLDOFF_EN, HOLDOFF_CYCLES=16): a repeat pulse on requester 1 five cycles after its grant -> ignored, no overrun; a pulse 20 cycles after the grant -> served.
REQ-034 Reset mid-operation: rst=1 during S_OFFER with 3 bits pending -> next cycle all outputs 0; no events until new pulses arrive.
